// File: rtl/cpu_net_iface.sv
// CPU-to-mesh network interface: packs CPU words into flits (TX FIFO) and filters/unpacks router flits (RX FIFO).
// Optional macro NI_PARITY_EN: generate parity on TX and discard flits with bad parity on RX.
module cpu_net_iface #(
  parameter logic [7:0] NODE_ID    = 8'h00,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_tx_data,
  input  logic [7:0]  cpu_tx_dst,
  input  logic        cpu_tx_valid,
  output logic        cpu_tx_ready,
  output logic [63:0] flit_out,
  output logic        flit_out_valid,
  input  logic        flit_out_ready,
  input  logic [63:0] flit_in,
  input  logic        flit_in_valid,
  output logic        flit_in_ready,
  output logic [31:0] cpu_rx_data,
  output logic [7:0]  cpu_rx_src,
  output logic        cpu_rx_valid,
  input  logic        cpu_rx_ready,
  output logic [7:0]  drop_count
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [63:0]   r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [AW:0]   r_tx_cnt;
  logic [7:0]    r_seq;

  logic [39:0]   r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [AW:0]   r_rx_cnt;
  logic [7:0]    r_drop_cnt;

  logic w_tx_push, w_tx_pop, w_tx_parity;
  logic w_rx_accept, w_rx_push, w_rx_drop, w_rx_pop, w_rx_parity_ok;
  logic w_unused;

`ifdef NI_PARITY_EN
  assign w_tx_parity    = ^cpu_tx_data;
  assign w_rx_parity_ok = (flit_in[39] == ^flit_in[31:0]);
`else
  assign w_tx_parity    = 1'b0;
  assign w_rx_parity_ok = 1'b1;
`endif

  // seq, parity and reserved fields of incoming flits carry nothing the CPU needs
  assign w_unused = ^flit_in[47:32];

  assign cpu_tx_ready   = (r_tx_cnt != L_DEPTH);
  assign flit_out_valid = (r_tx_cnt != '0);
  assign flit_out       = flit_out_valid ? r_tx_mem[r_tx_rptr] : '0;
  assign flit_in_ready  = (r_rx_cnt != L_DEPTH);
  assign cpu_rx_valid   = (r_rx_cnt != '0);
  assign {cpu_rx_src, cpu_rx_data} = cpu_rx_valid ? r_rx_mem[r_rx_rptr] : '0;
  assign drop_count     = r_drop_cnt;

  assign w_tx_push   = cpu_tx_valid && cpu_tx_ready;
  assign w_tx_pop    = flit_out_valid && flit_out_ready;
  assign w_rx_accept = flit_in_valid && flit_in_ready;
  assign w_rx_push   = w_rx_accept && (flit_in[63:56] == NODE_ID) && w_rx_parity_ok;
  assign w_rx_drop   = w_rx_accept && !w_rx_push;
  assign w_rx_pop    = cpu_rx_valid && cpu_rx_ready;

  // NOTE: storage arrays are deliberately left without reset; the occupancy
  // counters decide validity and the outputs are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wptr] <= {cpu_tx_dst, NODE_ID, r_seq, w_tx_parity, 7'b0, cpu_tx_data};
    if (w_rx_push)
      r_rx_mem[r_rx_wptr] <= {flit_in[55:48], flit_in[31:0]};
  end

  // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_cnt   <= '0;
      r_seq      <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wptr <= r_tx_wptr + 1'b1;
        r_seq     <= r_seq + 8'd1;
      end
      if (w_tx_pop)
        r_tx_rptr <= r_tx_rptr + 1'b1;
      r_tx_cnt <= r_tx_cnt + {{AW{1'b0}}, w_tx_push} - {{AW{1'b0}}, w_tx_pop};

      if (w_rx_push)
        r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)
        r_rx_rptr <= r_rx_rptr + 1'b1;
      r_rx_cnt <= r_rx_cnt + {{AW{1'b0}}, w_rx_push} - {{AW{1'b0}}, w_rx_pop};

      if (w_rx_drop && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/cpu_net_iface.md
# cpu_net_iface

Network interface placed between each CPU tile and its mesh router. It packetizes 32-bit CPU output words into 64-bit flits, buffering them until the router accepts them. It also filters and unpacks 64-bit flits arriving from the router into 32-bit words for the CPU input port. There is one instance per node, and it replaces the direct register copy between CPU and router ports.

## Interface
Parameters:
- NODE_ID, 8'h00, this node's address: [7:4] = x, [3:0] = y.
- FIFO_DEPTH, 4, entries per direction; must be a power of two, 2..16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_tx_data  in  32  payload word from the CPU.
- cpu_tx_dst  in  8  destination node ID.
- cpu_tx_valid  in  1  CPU offers a word.
- cpu_tx_ready  out  1  interface can accept the offered word.
- flit_out  out  64  flit to the router.
- flit_out_valid  out  1  flit_out is valid.
- flit_out_ready  in  1  router accepts the flit.
- flit_in  in  64  flit from the router.
- flit_in_valid  in  1  flit_in is valid.
- flit_in_ready  out  1  interface can accept the incoming flit.
- cpu_rx_data  out  32  received payload.
- cpu_rx_src  out  8  source node ID of the received payload.
- cpu_rx_valid  out  1  received word is available.
- cpu_rx_ready  in  1  CPU consumes the received word.
- drop_count  out  8  count of discarded incoming flits; saturates at 255.

## Operation
- Flit format: [63:56] dst, [55:48] src (= NODE_ID), [47:40] seq, [39] parity, [38:32] reserved (0), [31:0] payload.
- Transfer rule: a transfer occurs on any edge where valid && ready.

TX path:
- On each transfer, the assembled flit is pushed into the TX FIFO.
- seq is an 8-bit counter, incremented per accepted word; it wraps 255 -> 0.
- flit_out always shows the TX FIFO head. flit_out_valid = TX FIFO not empty.
- The head and valid are held stable until flit_out_ready is asserted.

RX path:
- An accepted flit whose dst == NODE_ID is pushed into the RX FIFO as {src, payload}.
- An accepted flit whose dst != NODE_ID is discarded and drop_count increments.
- cpu_rx_data and cpu_rx_src show the RX FIFO head. cpu_rx_valid = RX FIFO not empty.

Ready signals:
- cpu_tx_ready = TX FIFO not full.
- flit_in_ready = RX FIFO not full.
- Both are derived from registered occupancy counts only. There is no full-pass-through bypass.

Boundary conditions:
- Full FIFO with a pop on the same edge: ready is already low, so there is no push; occupancy drops by one.
- Non-full FIFO with a push and pop on the same edge: occupancy is unchanged and pointers wrap modulo FIFO_DEPTH.
- Empty FIFO: valid is low, and a ready assertion has no effect.
- drop_count stays at 255 once reached.

## Timing
- Reset (asynchronous, mid-operation included) flushes both FIFOs and clears seq and drop_count to 0.
- Output values in reset: cpu_tx_ready=1, flit_in_ready=1, flit_out_valid=0, cpu_rx_valid=0, flit_out=0, cpu_rx_data=0, cpu_rx_src=0, drop_count=0.
- TX latency: a word accepted at edge N gives flit_out_valid=1 after edge N (one cycle).
- RX latency: a flit accepted at edge N gives cpu_rx_valid=1 after edge N.
- Throughput: one transfer per cycle per direction, sustained.
- drop_count updates on the edge at which the mismatched flit is accepted.

## Configuration
- NI_PARITY_EN defined:
  - TX sets bit 39 to the even parity of bits [31:0] (XOR of the payload).
  - RX checks the parity. A flit with a parity mismatch is discarded even when its dst matches, and drop_count increments.
- NI_PARITY_EN undefined:
  - Bit 39 is driven to 0 on TX and ignored on RX.

## Test plan
- NODE_ID=8'h11; push payload 32'hDEADBEEF with dst 8'h22 and flit_out_ready=1 -> next cycle flit_out = 64'h2211_00_00_DEADBEEF (with NI_PARITY_EN, bit 39 = 0 since the payload has 24 ones); then seq=1.
- Hold flit_out_ready=0 and push 5 words at FIFO_DEPTH=4 -> cpu_tx_ready drops after the 4th push; then release ready -> 4 flits drain in order with seq 0,1,2,3.
- Inject a flit with dst 8'h33 at NODE_ID 8'h11 -> cpu_rx_valid stays 0 and drop_count=1; inject 300 such flits -> drop_count=255.
- Inject a flit with dst 8'h11, src 8'h05, payload 32'h0000_0042 -> next cycle cpu_rx_valid=1, cpu_rx_data=32'h42, cpu_rx_src=8'h05.
- Push 256 words -> the 257th flit has seq=0.
- Assert rst while both FIFOs hold 2 entries -> outputs immediately take their reset values; after release, the first flit carries seq=0.
- With NI_PARITY_EN: inject a matching-dst flit with bit 39 flipped -> the flit is dropped and drop_count increments.
